axis_uart_tx_arbiter: RTL and testbench

// - Shares one UART TX bridge (N_BYTES-wide AXIS word in, serial out) between N_INPUTS AXIS requesters.
// - Round-robin arbitration with packet lock: the grant is held until TLAST, or until MAX_BURST words.
// - Single registered output stage drives the bridge's S_AXIS port; sits between producers and axis_uart_bridge_tx.

---
 rtl/axis_uart_arb_pkg.sv | 26 ++
 rtl/axis_uart_tx_arbiter_pick.sv | 33 +++
 rtl/axis_uart_tx_arbiter.sv | 111 +++++++++++
 tb/tb_axis_uart_tx_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_uart_arb_pkg.sv
// Shared types and helpers for the AXIS-to-UART-TX round-robin arbiter.
// The grant FSM encoding, burst counter width and a reference next-index helper live here.
package axis_uart_arb_pkg;

  localparam int BURST_CNT_W = 16;
  localparam int MAX_REQ     = 16;

  typedef enum logic {IDLE_ST, GRANT_ST} arb_fsm;

  // Next requester after 'last' with wrap-around over n requesters; returns 'last' when none request.
  function automatic logic [3:0] rr_next(input logic [MAX_REQ-1:0] req, input logic [3:0] last,
                                         input int n);
    logic found;
    int   c;
    rr_next = last;
    found   = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      c = (int'(last) + k) % n;
      if (k <= n && !found && req[c]) begin
        rr_next = 4'(c);
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/axis_uart_tx_arbiter_pick.sv
// Combinational round-robin pick: the request vector is doubled, rotated so the
// requester after 'last' sits at bit 0, and the lowest set bit wins.
module rr_arbiter_pick #(
  parameter int N_INPUTS = 4,
  parameter int IDX_W    = $clog2(N_INPUTS)
) (
  input  logic [N_INPUTS-1:0] req,
  input  logic [IDX_W-1:0]    last,
  output logic [IDX_W-1:0]    pick,
  output logic                pick_valid
);

  logic [IDX_W-1:0]      start;
  logic [2*N_INPUTS-1:0] rotated;
  logic [IDX_W:0]        sum;

  always_comb begin
    start      = (last == IDX_W'(N_INPUTS - 1)) ? '0 : last + IDX_W'(1);
    rotated    = {req, req} >> start;
    pick_valid = 1'b0;
    sum        = '0;
    // Descending scan so the lowest rotated offset is the one left standing.
    for (int j = N_INPUTS - 1; j >= 0; j--) begin
      if (rotated[j]) begin
        pick_valid = 1'b1;
        sum        = {1'b0, start} + (IDX_W + 1)'(j);
      end
    end
    if (sum >= (IDX_W + 1)'(N_INPUTS)) sum = sum - (IDX_W + 1)'(N_INPUTS);
    pick = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/axis_uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART TX bridge among N_INPUTS AXIS producers.
// One registered output stage; GRANT_ACTIVE exposes the FSM state.
module axis_uart_tx_arbiter
  import axis_uart_arb_pkg::*;
#(
  parameter int N_INPUTS  = 4,
  parameter int N_BYTES   = 32,
  parameter int MAX_BURST = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_INPUTS*N_BYTES*8-1:0]   S_AXIS_TDATA,
  input  logic [N_INPUTS-1:0]             S_AXIS_TVALID,
  input  logic [N_INPUTS-1:0]             S_AXIS_TLAST,
  output logic [N_INPUTS-1:0]             S_AXIS_TREADY,
  output logic [N_BYTES*8-1:0]            M_AXIS_TDATA,
  output logic                            M_AXIS_TVALID,
  input  logic                            M_AXIS_TREADY,
  output logic [$clog2(N_INPUTS)-1:0]     GRANT_ID,
  output logic                            GRANT_ACTIVE
);

  localparam int IDX_W = $clog2(N_INPUTS);
  localparam int W     = N_BYTES * 8;
  localparam logic [BURST_CNT_W-1:0] BURST_LAST =
    (MAX_BURST == 0) ? '0 : BURST_CNT_W'(MAX_BURST - 1);

  // Handshake: a beat moves on an edge where VALID and READY are both high; a
  // producer's TREADY never depends on its own TVALID, and the output register
  // can take a beat whenever it is empty or being drained that same cycle.
  arb_fsm                 state, state_nxt;
  logic [IDX_W-1:0]       grant_id, grant_id_nxt;
  logic [BURST_CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  logic                   m_valid;
  logic [W-1:0]           m_data;
  logic                   out_free, accept, burst_end, pick_valid;
  logic [IDX_W-1:0]       pick;
  logic [W-1:0]           slices [N_INPUTS];

  for (genvar i = 0; i < N_INPUTS; i++) begin : g_slice
    assign slices[i] = S_AXIS_TDATA[i*W +: W];
  end

  rr_arbiter_pick #(.N_INPUTS(N_INPUTS), .IDX_W(IDX_W)) u_pick (
    .req        (S_AXIS_TVALID),
    .last       (grant_id),
    .pick       (pick),
    .pick_valid (pick_valid)
  );

  assign out_free  = ~m_valid | M_AXIS_TREADY;
  assign accept    = (state == GRANT_ST) & S_AXIS_TVALID[grant_id] & out_free;
  assign burst_end = (MAX_BURST != 0) && (burst_cnt == BURST_LAST);

  always_comb begin
    S_AXIS_TREADY = '0;
    if (state == GRANT_ST && out_free) S_AXIS_TREADY[grant_id] = 1'b1;
  end

  always_comb begin
    state_nxt     = state;
    grant_id_nxt  = grant_id;
    burst_cnt_nxt = burst_cnt;
    case (state)
      IDLE_ST: begin
        if (pick_valid) begin
          state_nxt    = GRANT_ST;
          grant_id_nxt = pick;
        end
      end
      GRANT_ST: begin
        // An idle grantee keeps the grant; only an accepted beat can release it.
        if (accept) begin
          if (S_AXIS_TLAST[grant_id] || burst_end) begin
            state_nxt     = IDLE_ST;
            burst_cnt_nxt = '0;
          end else begin
            burst_cnt_nxt = burst_cnt + BURST_CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE_ST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE_ST;
      grant_id  <= IDX_W'(N_INPUTS - 1);
      burst_cnt <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
    end else begin
      state     <= state_nxt;
      grant_id  <= grant_id_nxt;
      burst_cnt <= burst_cnt_nxt;
      if (accept) begin
        m_data  <= slices[grant_id];
        m_valid <= 1'b1;
      end else if (M_AXIS_TREADY) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign M_AXIS_TDATA  = m_data;
  assign M_AXIS_TVALID = m_valid;
  assign GRANT_ID      = grant_id;
  assign GRANT_ACTIVE  = (state == GRANT_ST);

endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// Bench for axis_uart_tx_arbiter: two instances (unlimited burst and MAX_BURST=2) driven
// from per-requester packet queues and checked every cycle against a transaction-level model.
module tb_axis_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int NB = 4;
  localparam int W  = NB * 8;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [N*W-1:0] s_tdata  [2];
  logic [N-1:0]   s_tvalid [2];
  logic [N-1:0]   s_tlast  [2];
  logic           m_tready [2];

  logic [N-1:0]  s_tready_a, s_tready_b;
  logic [W-1:0]  m_tdata_a, m_tdata_b;
  logic          m_tvalid_a, m_tvalid_b;
  logic [IW-1:0] grant_id_a, grant_id_b;
  logic          grant_active_a, grant_active_b;

  axis_uart_tx_arbiter #(.N_INPUTS(N), .N_BYTES(NB), .MAX_BURST(0)) dut_a (
    .clk(clk), .reset(reset),
    .S_AXIS_TDATA(s_tdata[0]), .S_AXIS_TVALID(s_tvalid[0]), .S_AXIS_TLAST(s_tlast[0]),
    .S_AXIS_TREADY(s_tready_a), .M_AXIS_TDATA(m_tdata_a), .M_AXIS_TVALID(m_tvalid_a),
    .M_AXIS_TREADY(m_tready[0]), .GRANT_ID(grant_id_a), .GRANT_ACTIVE(grant_active_a)
  );

  axis_uart_tx_arbiter #(.N_INPUTS(N), .N_BYTES(NB), .MAX_BURST(2)) dut_b (
    .clk(clk), .reset(reset),
    .S_AXIS_TDATA(s_tdata[1]), .S_AXIS_TVALID(s_tvalid[1]), .S_AXIS_TLAST(s_tlast[1]),
    .S_AXIS_TREADY(s_tready_b), .M_AXIS_TDATA(m_tdata_b), .M_AXIS_TVALID(m_tvalid_b),
    .M_AXIS_TREADY(m_tready[1]), .GRANT_ID(grant_id_b), .GRANT_ACTIVE(grant_active_b)
  );

  // Stimulus sources: each word is {last, requester, packet number, word index}.
  logic [W:0]   src_q [2][N][$];
  logic [W-1:0] exp_q [2][$];
  int           out_ids   [2][$];
  int           out_steps [2][$];

  // Transaction-level model: who owns the bridge, how many words of the grant went, what sits in the output slot.
  bit           mv [2];
  logic [W-1:0] md [2];
  bit           busy [2];
  int           gid [2];
  int           burst [2];
  int           max_burst [2] = '{0, 2};

  int   vprob = 100, rprob = 100;
  bit   force_stall = 1'b0;
  bit   rst_req = 1'b1;
  int   step_cnt = 0;
  int   n_checks = 0, n_fail = 0;
  logic [7:0] pkt_no = 8'd0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (step %0d)", name, got, exp_v, step_cnt);
    end
  endtask

  function automatic int q_at(input int u, input int k, input bit steps);
    if (steps) return (k < out_steps[u].size()) ? out_steps[u][k] : -1;
    return (k < out_ids[u].size()) ? out_ids[u][k] : -1;
  endfunction

  task automatic model_reset(input int u);
    mv[u] = 1'b0; md[u] = '0; busy[u] = 1'b0; gid[u] = N - 1; burst[u] = 0;
  endtask

  task automatic load_pkt(input int u, input int r, input int len);
    for (int k = 0; k < len; k++) src_q[u][r].push_back({1'(k == len - 1), 8'(r), pkt_no, 16'(k)});
    pkt_no++;
  endtask

  task automatic drive_inputs();
    reset = rst_req;
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < N; i++) begin
        if (src_q[u][i].size() > 0 && $urandom_range(0, 99) < vprob) begin
          s_tvalid[u][i]        = 1'b1;
          s_tlast[u][i]         = src_q[u][i][0][W];
          s_tdata[u][i*W +: W]  = src_q[u][i][0][W-1:0];
        end else begin
          s_tvalid[u][i]        = 1'b0;
          s_tlast[u][i]         = 1'($urandom_range(0, 1));
          s_tdata[u][i*W +: W]  = $urandom;
        end
      end
      m_tready[u] = !force_stall && ($urandom_range(0, 99) < rprob);
    end
  endtask

  task automatic check_and_advance(input int u);
    logic [N-1:0]  exp_rdy, d_rdy;
    logic [W-1:0]  d_data, sl;
    logic          d_valid, d_active, lst;
    logic [IW-1:0] d_gid;
    bit            free, acc;
    d_rdy    = u ? s_tready_b : s_tready_a;
    d_data   = u ? m_tdata_b : m_tdata_a;
    d_valid  = u ? m_tvalid_b : m_tvalid_a;
    d_active = u ? grant_active_b : grant_active_a;
    d_gid    = u ? grant_id_b : grant_id_a;
    free     = !mv[u] || m_tready[u];
    exp_rdy  = '0;
    if (busy[u] && free) exp_rdy[gid[u]] = 1'b1;
    check($sformatf("u%0d m_tvalid", u), W'(d_valid), W'(mv[u]));
    check($sformatf("u%0d m_tdata", u), d_data, md[u]);
    check($sformatf("u%0d s_tready", u), W'(d_rdy), W'(exp_rdy));
    check($sformatf("u%0d grant_id", u), W'(d_gid), W'(gid[u]));
    check($sformatf("u%0d grant_active", u), W'(d_active), W'(busy[u]));
    if (d_valid === 1'b1 && m_tready[u] && !reset) begin
      if (exp_q[u].size() == 0) begin
        check($sformatf("u%0d unexpected beat", u), d_data, 'x);
      end else begin
        check($sformatf("u%0d beat order", u), d_data, exp_q[u].pop_front());
      end
      out_ids[u].push_back(int'(d_data[31:24]));
      out_steps[u].push_back(step_cnt);
    end
    if (reset) begin
      model_reset(u);
      exp_q[u].delete();
      return;
    end
    sl  = s_tdata[u][gid[u]*W +: W];
    lst = s_tlast[u][gid[u]];
    acc = busy[u] && s_tvalid[u][gid[u]] && free;
    if (acc) begin
      md[u] = sl;
      mv[u] = 1'b1;
      exp_q[u].push_back(sl);
      void'(src_q[u][gid[u]].pop_front());
    end else if (m_tready[u]) begin
      mv[u] = 1'b0;
    end
    if (!busy[u]) begin
      for (int k = 1; k <= N; k++) begin
        if (s_tvalid[u][(gid[u] + k) % N]) begin
          gid[u]  = (gid[u] + k) % N;
          busy[u] = 1'b1;
          break;
        end
      end
    end else if (acc) begin
      if (lst || (max_burst[u] != 0 && burst[u] == max_burst[u] - 1)) begin
        busy[u]  = 1'b0;
        burst[u] = 0;
      end else begin
        burst[u]++;
      end
    end
  endtask

  task automatic step();
    step_cnt++;
    @(negedge clk);
    drive_inputs();
    #1;
    for (int u = 0; u < 2; u++) check_and_advance(u);
  endtask

  function automatic bit all_idle();
    for (int u = 0; u < 2; u++) begin
      if (mv[u] || busy[u] || exp_q[u].size() != 0) return 1'b0;
      for (int i = 0; i < N; i++) if (src_q[u][i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while (!all_idle() && n < budget) begin
      step();
      n++;
    end
    n_checks++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL drain timeout: got %0d cycles required fewer than %0d", n, budget);
    end
  endtask

  task automatic clear_log();
    for (int u = 0; u < 2; u++) begin
      out_ids[u].delete();
      out_steps[u].delete();
    end
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ls, n;
    int exp_ids [$];
    logic [W-1:0] held;
    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin
      s_tdata[u] = '0; s_tvalid[u] = '0; s_tlast[u] = '0; m_tready[u] = 1'b0;
      model_reset(u);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset m_tvalid", W'(m_tvalid_a), '0);
    check("reset m_tdata", m_tdata_a, '0);
    check("reset s_tready", W'(s_tready_a | s_tready_b), '0);
    check("reset grant_id", W'(grant_id_a), W'(N - 1));
    check("reset grant_active", W'(grant_active_a | grant_active_b), '0);
    step();
    rst_req = 1'b0;

    // Single requester 2, three words, no backpressure.
    clear_log();
    load_pkt(0, 2, 3);
    ls = step_cnt + 1;
    drain(100);
    check("t1 beats", W'(out_ids[0].size()), W'(3));
    check("t1 ids", W'(q_at(0, 0, 0) + q_at(0, 1, 0) + q_at(0, 2, 0)), W'(6));
    check("t1 first beat step", W'(q_at(0, 0, 1)), W'(ls + 2));
    check("t1 last beat step", W'(q_at(0, 2, 1)), W'(ls + 4));
    check("t1 grant_id", W'(grant_id_a), W'(2));
    check("t1 grant_active", W'(grant_active_a), '0);

    // All four requesting one-word packets right after reset.
    rst_req = 1'b1; step(); rst_req = 1'b0;
    clear_log();
    load_pkt(0, 0, 1); load_pkt(0, 0, 1);
    for (int r = 1; r < N; r++) load_pkt(0, r, 1);
    drain(100);
    exp_ids = '{0, 1, 2, 3, 0};
    foreach (exp_ids[k]) check($sformatf("t2 grant %0d", k), W'(q_at(0, k, 0)), W'(exp_ids[k]));
    for (int k = 1; k < 5; k++)
      check($sformatf("t2 spacing %0d", k), W'(q_at(0, k, 1) - q_at(0, k - 1, 1)), W'(2));

    // Requester 1 holds the bridge for its 4-word packet while requester 0 waits.
    clear_log();
    load_pkt(0, 0, 2);
    load_pkt(0, 1, 4);
    drain(100);
    exp_ids = '{1, 1, 1, 1, 0, 0};
    foreach (exp_ids[k]) check($sformatf("t3 beat %0d", k), W'(q_at(0, k, 0)), W'(exp_ids[k]));

    // Backpressure for 10 cycles in the middle of a 6-word packet.
    clear_log();
    load_pkt(0, 3, 6);
    n = 0;
    while (out_ids[0].size() < 2 && n < 50) begin step(); n++; end
    force_stall = 1'b1;
    step();
    held = m_tdata_a;
    repeat (9) step();
    check("t4 held valid", W'(m_tvalid_a), W'(1));
    check("t4 held data", m_tdata_a, held);
    check("t4 held word", W'(m_tdata_a[15:0]), W'(2));
    check("t4 stalled tready", W'(s_tready_a), '0);
    force_stall = 1'b0;
    drain(100);
    check("t4 beats", W'(out_ids[0].size()), W'(6));

    // MAX_BURST=2 instance: two 5-word streams interleave in pairs.
    clear_log();
    load_pkt(1, 0, 5);
    load_pkt(1, 1, 5);
    drain(200);
    exp_ids = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 1};
    foreach (exp_ids[k]) check($sformatf("t5 beat %0d", k), W'(q_at(1, k, 0)), W'(exp_ids[k]));

    // Random traffic on both instances with random valid gaps and backpressure.
    vprob = 70; rprob = 60;
    for (int round = 0; round < 8; round++) begin
      for (int u = 0; u < 2; u++)
        for (int r = 0; r < N; r++)
          if ($urandom_range(0, 1) == 1) load_pkt(u, r, $urandom_range(1, 6));
      drain(3000);
    end
    vprob = 100; rprob = 100;

    // Reset while word 2 of a 4-word packet from requester 2 sits in the output slot.
    clear_log();
    load_pkt(0, 2, 4);
    n = 0;
    while (out_ids[0].size() < 1 && n < 50) begin step(); n++; end
    rst_req = 1'b1; step(); rst_req = 1'b0;
    for (int u = 0; u < 2; u++) for (int r = 0; r < N; r++) src_q[u][r].delete();
    clear_log();
    load_pkt(0, 3, 1);
    load_pkt(0, 0, 1);
    step();
    check("t7 m_tvalid after reset", W'(m_tvalid_a), '0);
    check("t7 s_tready after reset", W'(s_tready_a), '0);
    check("t7 grant_id after reset", W'(grant_id_a), W'(N - 1));
    drain(100);
    check("t7 first winner", W'(q_at(0, 0, 0)), W'(0));
    check("t7 second winner", W'(q_at(0, 1, 0)), W'(3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
